// File: rtl/bit_serial_adder_if.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_if
//   Request/result bundle for bit_serial_adder.
//
//   Handshake: the requester raises start with a, b and cin valid. The adder
//   accepts the request on a rising clk edge when it is not busy (IDLE or DONE
//   state). From acceptance until the result is ready busy stays high, and a
//   start seen while busy is ignored. done pulses for exactly one cycle when
//   sum/cout (and ovf) are valid. Those outputs then hold until the next
//   accepted start.
//
//   Signals
//     start      master->slave  request an addition
//     a, b       master->slave  operands, WIDTH bits
//     cin        master->slave  carry-in
//     busy       slave->master  addition in progress
//     done       slave->master  one-cycle result-valid pulse
//     sum        slave->master  registered result, WIDTH bits
//     cout       slave->master  registered carry out of bit WIDTH-1
//     ovf        slave->master  signed overflow (only with BIT_SERIAL_ADDER_OVF_EN)
//     dbg_state  slave->master  current FSM state for observation
// -----------------------------------------------------------------------------
interface bit_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif
   logic [1:0]       dbg_state;

`ifdef BIT_SERIAL_ADDER_OVF_EN
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf, dbg_state
   );
   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf, dbg_state
   );
`else
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, dbg_state
   );
   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, dbg_state
   );
`endif
endinterface

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//   Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first.
//   There are three states. IDLE waits for start. SHIFT runs one full-add per
//   cycle for WIDTH cycles. DONE pulses done for one cycle. A start seen in
//   DONE goes straight back into SHIFT, so with start held high a new result
//   comes out every WIDTH+1 cycles.
//
//   Parameters
//     WIDTH  operand and sum width; must be at least 2
//
//   Ports
//     clk    rising-edge clock
//     rst    synchronous active-high reset
//     bus    bit_serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout
//            out, plus dbg_state)
//
//   Optional feature
//     Defining BIT_SERIAL_ADDER_OVF_EN adds bus.ovf, the signed overflow flag.
//     It is registered with the result and held with it.
// -----------------------------------------------------------------------------
module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   bit_serial_adder_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic [CNT_W-1:0] cnt;
`ifdef BIT_SERIAL_ADDER_OVF_EN
   logic             ovf_reg;
`endif

   logic s_bit;
   logic c_bit;
   logic accept;

   // Full adder on the current LSBs and the running carry.
   assign s_bit = a_reg[0] ^ b_reg[0] ^ carry_reg;
   assign c_bit = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

   // A request is taken whenever the engine is not shifting.
   assign accept = bus.start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         cnt       <= '0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
         ovf_reg   <= 1'b0;
`endif
      end else if (accept) begin
         // sum_reg is left alone here. The old bits are shifted out during
         // SHIFT, so the previous result stays visible until then.
         a_reg     <= bus.a;
         b_reg     <= bus.b;
         carry_reg <= bus.cin;
         cnt       <= '0;
         state     <= SHIFT;
      end else begin
         case (state)
            SHIFT: begin
               sum_reg   <= {s_bit, sum_reg[WIDTH-1:1]};
               a_reg     <= a_reg >> 1;
               b_reg     <= b_reg >> 1;
               carry_reg <= c_bit;
               cnt       <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  // On the MSB step, carry_reg is the carry into bit WIDTH-1
                  // and c_bit is the carry out of it.
                  cout_reg <= c_bit;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                  ovf_reg  <= carry_reg ^ c_bit;
`endif
                  state    <= DONE;
               end
            end
            default: state <= IDLE;  // IDLE or DONE without start
         endcase
      end
   end

   assign bus.busy      = (state == SHIFT);
   assign bus.done      = (state == DONE);
   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;
   assign bus.dbg_state = state;
`ifdef BIT_SERIAL_ADDER_OVF_EN
   assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//   Self-checking bench for bit_serial_adder (WIDTH=8). A transaction-level
//   model tracks how many shift cycles remain and the queued arithmetic
//   result (a+b+cin). The monitor compares every cycle against it. Directed
//   cases also pin literal results, latency and done spacing. Random traffic
//   follows, with occasional resets.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         cin   = 1'b0;

   bit_serial_adder_if #(.WIDTH(W)) bus ();

   assign bus.start = start;
   assign bus.a     = a;
   assign bus.b     = b;
   assign bus.cin   = cin;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + monitor ----------------
   logic [W:0] exp_q[$];   // {cout, sum} per accepted request
   logic       ovf_q[$];
   int         remaining = 0;
   logic       m_done = 1'b0;
   logic [W-1:0] m_sum = '0;
   logic       m_cout = 1'b0;
   logic       m_ovf  = 1'b0;

   initial begin : monitor
      logic s_rst, s_start, s_cin;
      logic [W-1:0] s_a, s_b;
      logic [W:0]   full;
      logic [W:0]   res;
      forever begin
         @(posedge clk);
         s_rst = rst; s_start = start; s_a = a; s_b = b; s_cin = cin;
         if (s_rst) begin
            remaining = 0; m_done = 1'b0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
            exp_q.delete(); ovf_q.delete();
         end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
               res    = exp_q.pop_front();
               m_cout = res[W];
               m_sum  = res[W-1:0];
               m_ovf  = ovf_q.pop_front();
               m_done = 1'b1;
            end
         end else begin
            m_done = 1'b0;
            if (s_start) begin
               full = {1'b0, s_a} + {1'b0, s_b} + {{W{1'b0}}, s_cin};
               exp_q.push_back(full);
               // signed overflow: equal operand signs, different result sign
               ovf_q.push_back((s_a[W-1] == s_b[W-1]) && (full[W-1] != s_a[W-1]));
               remaining = W;
            end
         end
         @(negedge clk);
         #1;
         check("mon_done", {31'd0, bus.done}, {31'd0, m_done});
         check("mon_busy", {31'd0, bus.busy}, {31'd0, remaining > 0});
         if (remaining == 0) begin
            check("mon_sum",  {24'd0, bus.sum}, {24'd0, m_sum});
            check("mon_cout", {31'd0, bus.cout}, {31'd0, m_cout});
`ifdef BIT_SERIAL_ADDER_OVF_EN
            check("mon_ovf",  {31'd0, bus.ovf}, {31'd0, m_ovf});
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic s, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic c);
      @(negedge clk);
      rst = r; start = s; a = aa; b = bb; cin = c;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   // Start one operation, wait (bounded) for done, compare against literals.
   task automatic literal_op(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                             input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
      int n;
      int busy_cycles;
      drive(1'b0, 1'b1, aa, bb, c);
      drive(1'b0, 1'b0, pick(), pick(), 1'b0);
      #1;
      n = 0;
      busy_cycles = 0;
      while (!bus.done && n < 20) begin
         if (bus.busy) busy_cycles++;
         drive(1'b0, 1'b0, pick(), pick(), 1'b0);
         #1;
         n++;
      end
      check({name, "_done_seen"}, {31'd0, bus.done}, 32'd1);
      check({name, "_latency"}, n, W);
      check({name, "_busy_cycles"}, busy_cycles, W);
      check({name, "_sum"}, {24'd0, bus.sum}, {24'd0, es});
      check({name, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
`ifdef BIT_SERIAL_ADDER_OVF_EN
      check({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
`else
      if (eo === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int ndone;
      int last;
      repeat (3) drive(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_sum",  {24'd0, bus.sum},  32'd0);
      check("rst_cout", {31'd0, bus.cout}, 32'd0);

      literal_op("op_0f_01",    8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      literal_op("op_ff_01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      literal_op("op_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      literal_op("op_7f_01",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      literal_op("op_80_80",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      literal_op("op_00_00",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

      // start pulsed during SHIFT must be ignored
      drive(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 1'b1, 8'hAA, 8'h55, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      ndone = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (bus.done) begin
            ndone++;
            check("ignore_sum", {24'd0, bus.sum}, 32'h03);
         end
         drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      end
      check("ignore_single_done", ndone, 1);

      // reset in the middle of SHIFT
      drive(1'b0, 1'b1, 8'h33, 8'h44, 1'b0);
      repeat (4) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      #1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_done", {31'd0, bus.done}, 32'd0);
      check("midrst_sum",  {24'd0, bus.sum},  32'd0);
      check("midrst_cout", {31'd0, bus.cout}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
         #1;
         if (bus.done) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      literal_op("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

      // start held high: back-to-back operations
      ndone = 0;
      last = -1;
      for (int i = 0; i < 46; i++) begin
         drive(1'b0, 1'b1, pick(), pick(), 1'($urandom_range(0, 1)));
         #1;
         if (bus.done) begin
            if (last >= 0) check("b2b_spacing", i - last, W + 1);
            last = i;
            ndone++;
         end
      end
      check("b2b_count", ndone, 5);
      repeat (12) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

      // random traffic with occasional reset; the monitor checks every cycle
      for (int i = 0; i < 2000; i++) begin
         drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) == 0),
               pick(), pick(), 1'($urandom_range(0, 1)));
      end
      repeat (12) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      #2;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; SHALL be at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse when sum and cout are valid.
REQ-010 sum  output  WIDTH  result, registered.
REQ-011 cout  output  1  carry-out of bit WIDTH-1, registered.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 SHALL capture a, b and cin into internal registers, clear the bit counter, and move to SHIFT; start=0 SHALL stay in IDLE.
REQ-014 SHIFT: each cycle SHALL full-add a_reg[0], b_reg[0] and carry_reg (s = xor of the three, c = majority of the three).
REQ-015 In the same cycle, SHIFT SHALL shift the sum bit into sum_reg at MSB with a right shift, shift a_reg and b_reg right by one, load c into carry_reg, and increment the counter.
REQ-016 The counter SHALL be ceil(log2(WIDTH+1)) bits wide; SHIFT SHALL last exactly WIDTH cycles, then move to DONE.
REQ-017 DONE: done=1 for exactly one cycle; cout SHALL equal carry_reg; next state SHALL be SHIFT if start=1 (new operands captured), else IDLE.
REQ-018 Latency: with start accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH (WIDTH+1 cycles start-to-done).
REQ-019 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-020 start asserted while in SHIFT SHALL be ignored, with no effect on operands or timing.
REQ-021 sum and cout SHALL hold the last result stably in IDLE and DONE until the next accepted start; sum is not guaranteed during SHIFT.
REQ-022 The result SHALL equal (a + b + cin) mod 2^WIDTH; cout SHALL be the bit-WIDTH carry, with no exceptions at all-ones or zero operands.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, with busy=0, done=0, sum=0, cout=0, counter=0, carry_reg=0 and operand registers=0.
REQ-024 rst SHALL override start and any in-progress operation; an operation interrupted by reset SHALL produce no done pulse.
REQ-025 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-026 Macro BIT_SERIAL_ADDER_OVF_EN SHALL control signed overflow reporting.
REQ-027 With BIT_SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf (1 bit).
REQ-028 ovf SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, registered in the final SHIFT cycle, valid with done, held like sum, and reset to 0.
REQ-029 With BIT_SERIAL_ADDER_OVF_EN undefined, port ovf and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification (WIDTH=8)
REQ-030 a=0x0F, b=0x01, cin=0, start at edge 0 -> done high after edge 8, sum=0x10, cout=0, busy high for 8 cycles.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0 (when enabled); a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-033 Start a=0x01, b=0x02, then pulse start with a=0xAA during SHIFT -> second request ignored, sum=0x03, single done.
REQ-034 rst asserted at SHIFT cycle 4 -> next cycle IDLE, all outputs 0, no done; new start a=0x10, b=0x20 -> sum=0x30.
REQ-035 start held high continuously -> back-to-back operations, done every 9 cycles via DONE->SHIFT, each result correct.
